fetch_unit: RTL and testbench

//  Parametrised PC/fetch stage for the next-generation CPU: owns the PC, fetches from a variable-latency

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/fetch_unit_if.sv | 32 +++
 rtl/fetch_unit_branch_cond.sv | 31 +++
 rtl/fetch_unit.sv | 101 ++++++++++
 tb/tb_fetch_unit.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch condition codes, HLT opcode and fetch FSM states.
package cpu_pkg;

    localparam logic [2:0] CC_NE     = 3'b000;
    localparam logic [2:0] CC_EQ     = 3'b001;
    localparam logic [2:0] CC_GT     = 3'b010;
    localparam logic [2:0] CC_LT     = 3'b011;
    localparam logic [2:0] CC_GE     = 3'b100;
    localparam logic [2:0] CC_LE     = 3'b101;
    localparam logic [2:0] CC_OVF    = 3'b110;
    localparam logic [2:0] CC_UNCOND = 3'b111;

    localparam logic [3:0] OPC_HLT = 4'hF;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: I-mem request/response plus the decode handshake and branch inputs.
interface fetch_unit_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16,
    parameter int OFF_W   = 9
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               imem_valid;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               instr_ack;
    logic               br_en;
    logic               br_reg;
    logic [2:0]         br_cond;
    logic [OFF_W-1:0]   br_offset;
    logic [ADDR_W-1:0]  br_target;
    logic [2:0]         flags;

    modport master (
        output imem_req, imem_addr, instr, instr_valid,
        input  imem_rdata, imem_valid, instr_ack,
               br_en, br_reg, br_cond, br_offset, br_target, flags
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_valid,
        output imem_rdata, imem_valid, instr_ack,
               br_en, br_reg, br_cond, br_offset, br_target, flags
    );
endinterface

// File: rtl/fetch_unit_branch_cond.sv
// Branch condition evaluator: maps {Z,V,N} flags and a condition code to taken/not-taken.
module branch_cond
    import cpu_pkg::*;
(
    input  logic [2:0] i_flags,
    input  logic [2:0] i_br_cond,
    output logic       o_cond_true
);
    logic w_z;
    logic w_v;
    logic w_n;

    assign w_z = i_flags[2];
    assign w_v = i_flags[1];
    assign w_n = i_flags[0];

    always_comb begin
        o_cond_true = 1'b0;
        case (i_br_cond)
            CC_NE:     o_cond_true = ~w_z;
            CC_EQ:     o_cond_true = w_z;
            CC_GT:     o_cond_true = ~w_z & ~w_n;
            CC_LT:     o_cond_true = w_n;
            CC_GE:     o_cond_true = w_z | ~w_n;
            CC_LE:     o_cond_true = w_z | w_n;
            CC_OVF:    o_cond_true = w_v;
            CC_UNCOND: o_cond_true = 1'b1;
            default:   o_cond_true = 1'b0;
        endcase
    end
endmodule

// File: rtl/fetch_unit.sv
// PC/fetch stage: fetches from variable-latency I-mem, holds the instruction for decode,
// resolves branches at acknowledge time and parks in HALT on an HLT opcode.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 16,
    parameter int                PC_INCR  = 2,
    parameter int                OFF_W    = 9,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    fetch_unit_if.master      bus,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus,
    output logic              hlt
);
    fetch_state_t       r_state;
    fetch_state_t       w_state_next;
    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_instr;

    logic               w_capture;
    logic               w_advance;
    logic               w_cond_true;
    logic               w_taken;
    logic [3:0]         w_opcode;
    logic [ADDR_W-1:0]  w_pc_plus;
    logic [ADDR_W-1:0]  w_offset_sext;
    logic [ADDR_W-1:0]  w_next_pc;

    branch_cond u_branch_cond (
        .i_flags     (bus.flags),
        .i_br_cond   (bus.br_cond),
        .o_cond_true (w_cond_true)
    );

    assign w_opcode      = bus.imem_rdata[INSTR_W-1 -: 4];
    assign w_pc_plus     = r_pc + ADDR_W'(PC_INCR);
    assign w_offset_sext = {{(ADDR_W-OFF_W){bus.br_offset[OFF_W-1]}}, bus.br_offset};
    assign w_taken       = bus.br_en & w_cond_true;

    // Offsets count instructions, so scale by two before adding; all sums wrap modulo 2^ADDR_W.
    always_comb begin
        w_next_pc = w_pc_plus;
        if (w_taken) begin
            if (bus.br_reg) w_next_pc = bus.br_target;
            else            w_next_pc = w_pc_plus + (w_offset_sext << 1);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            FETCH, WAIT: begin
                if (bus.imem_valid) begin
                    if (w_opcode == OPC_HLT) begin
                        w_state_next = HALT;
                    end else begin
                        w_capture    = 1'b1;
                        w_state_next = HOLD;
                    end
                end else begin
                    w_state_next = WAIT;
                end
            end
            HOLD: begin
                if (bus.instr_ack) begin
                    w_advance    = 1'b1;
                    w_state_next = FETCH;
                end
            end
            HALT:    w_state_next = HALT;
            default: w_state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
            r_pc    <= RESET_PC;
            r_instr <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_capture) r_instr <= bus.imem_rdata;
            if (w_advance) r_pc    <= w_next_pc;
        end
    end

    // Request is gated by rst so nothing is issued to I-mem while reset is held.
    assign bus.imem_req    = ((r_state == FETCH) || (r_state == WAIT)) && !rst;
    assign bus.imem_addr   = r_pc;
    assign bus.instr       = r_instr;
    assign bus.instr_valid = (r_state == HOLD);
    assign pc              = r_pc;
    assign pc_plus         = w_pc_plus;
    assign hlt             = (r_state == HALT);
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: variable-latency I-mem responder, branch vector table, halt/reset sequences.
module tb_fetch_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pc;
    logic [15:0] pc_plus;
    logic        hlt;

    int          checks = 0;
    int          errors = 0;
    int          lat = 0;
    int          cnt = 0;
    logic [15:0] halt_addr = 16'hFFFF;

    fetch_unit_if #(.ADDR_W(16), .INSTR_W(16), .OFF_W(9)) bus ();

    fetch_unit #(.ADDR_W(16), .INSTR_W(16), .PC_INCR(2), .OFF_W(9), .RESET_PC(16'h0000)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.master),
        .pc      (pc),
        .pc_plus (pc_plus),
        .hlt     (hlt)
    );

    always #5 clk = ~clk;

    // I-mem: answers after lat waiting cycles; word at halt_addr is HLT, others tag the address.
    always @(posedge clk) begin
        if (rst || !bus.imem_req || bus.imem_valid) cnt <= 0;
        else                                        cnt <= cnt + 1;
    end
    assign bus.imem_valid = bus.imem_req && (cnt >= lat);
    assign bus.imem_rdata = (bus.imem_addr == halt_addr) ? 16'hF000 : {4'h1, bus.imem_addr[11:0]};

    typedef struct {
        logic [15:0] start_pc;
        logic        br_en;
        logic        br_reg;
        logic [2:0]  cond;
        logic [8:0]  off;
        logic [15:0] tgt;
        logic [2:0]  flags;
        logic [15:0] exp_plus;
        logic [15:0] exp_next;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_hold(output int cyc);
        cyc = 0;
        while (!bus.instr_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus.instr_valid) begin
            checks++;
            errors++;
            $display("FAIL hold_timeout actual=%0d cycles required=instr_valid", cyc);
        end
    endtask

    task automatic ack(input logic en, input logic reg_br, input logic [2:0] cond,
                       input logic [8:0] off, input logic [15:0] tgt, input logic [2:0] fl);
        bus.br_en     = en;
        bus.br_reg    = reg_br;
        bus.br_cond   = cond;
        bus.br_offset = off;
        bus.br_target = tgt;
        bus.flags     = fl;
        bus.instr_ack = 1'b1;
        @(negedge clk);
        bus.instr_ack = 1'b0;
        bus.br_en     = 1'b0;
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        logic [15:0] e;

        vecs[0]  = '{16'h0010, 1'b1, 1'b0, CC_EQ,     9'h1FD, 16'h0000, 3'b100, 16'h0012, 16'h000C};
        vecs[1]  = '{16'h0010, 1'b1, 1'b0, CC_EQ,     9'h1FD, 16'h0000, 3'b000, 16'h0012, 16'h0012};
        vecs[2]  = '{16'h0020, 1'b1, 1'b1, CC_UNCOND, 9'h000, 16'h1234, 3'b000, 16'h0022, 16'h1234};
        vecs[3]  = '{16'h0020, 1'b1, 1'b1, CC_OVF,    9'h000, 16'h1234, 3'b000, 16'h0022, 16'h0022};
        vecs[4]  = '{16'hFFFE, 1'b0, 1'b0, CC_UNCOND, 9'h000, 16'h0000, 3'b000, 16'h0000, 16'h0000};
        vecs[5]  = '{16'h0100, 1'b1, 1'b0, CC_NE,     9'h005, 16'h0000, 3'b000, 16'h0102, 16'h010C};
        vecs[6]  = '{16'h0100, 1'b1, 1'b0, CC_NE,     9'h005, 16'h0000, 3'b100, 16'h0102, 16'h0102};
        vecs[7]  = '{16'h0200, 1'b1, 1'b0, CC_GT,     9'h004, 16'h0000, 3'b000, 16'h0202, 16'h020A};
        vecs[8]  = '{16'h0200, 1'b1, 1'b0, CC_GT,     9'h004, 16'h0000, 3'b001, 16'h0202, 16'h0202};
        vecs[9]  = '{16'h0300, 1'b1, 1'b0, CC_LT,     9'h1FF, 16'h0000, 3'b001, 16'h0302, 16'h0300};
        vecs[10] = '{16'h0300, 1'b1, 1'b0, CC_GE,     9'h007, 16'h0000, 3'b001, 16'h0302, 16'h0302};
        vecs[11] = '{16'h0400, 1'b1, 1'b0, CC_LE,     9'h002, 16'h0000, 3'b100, 16'h0402, 16'h0406};
        vecs[12] = '{16'h0400, 1'b1, 1'b0, CC_LE,     9'h002, 16'h0000, 3'b000, 16'h0402, 16'h0402};
        vecs[13] = '{16'h0500, 1'b1, 1'b0, CC_OVF,    9'h100, 16'h0000, 3'b010, 16'h0502, 16'h0302};
        vecs[14] = '{16'h0500, 1'b0, 1'b1, CC_UNCOND, 9'h000, 16'h1234, 3'b000, 16'h0502, 16'h0502};
        vecs[15] = '{16'h0000, 1'b1, 1'b0, CC_UNCOND, 9'h0FF, 16'h0000, 3'b000, 16'h0002, 16'h0200};
        vecs[16] = '{16'hFFFE, 1'b1, 1'b0, CC_UNCOND, 9'h001, 16'h0000, 3'b000, 16'h0000, 16'h0002};
        vecs[17] = '{16'h0600, 1'b1, 1'b0, CC_GE,     9'h001, 16'h0000, 3'b101, 16'h0602, 16'h0604};

        bus.instr_ack = 1'b0;
        bus.br_en     = 1'b0;
        bus.br_reg    = 1'b0;
        bus.br_cond   = 3'b000;
        bus.br_offset = '0;
        bus.br_target = '0;
        bus.flags     = 3'b000;

        // Reset state and sequential fetch with zero-wait memory
        @(negedge clk);
        check("rst_req",   16'(bus.imem_req), 16'h0);
        check("rst_valid", 16'(bus.instr_valid), 16'h0);
        check("rst_instr", bus.instr, 16'h0000);
        check("rst_hlt",   16'(hlt), 16'h0);
        check("rst_pc",    pc, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("seq_req0",  16'(bus.imem_req), 16'h1);
        check("seq_addr0", bus.imem_addr, 16'h0000);
        wait_hold(cyc);
        check("zero_wait_latency", 16'(cyc), 16'd1);
        check("seq_instr0", bus.instr, 16'h1000);
        @(negedge clk);
        check("hold_valid_kept", 16'(bus.instr_valid), 16'h1);
        check("hold_instr_kept", bus.instr, 16'h1000);
        ack(1'b0, 1'b0, CC_NE, 9'h0, 16'h0, 3'b000);
        check("seq_addr1", bus.imem_addr, 16'h0002);
        wait_hold(cyc);
        check("seq_instr1", bus.instr, 16'h1002);
        ack(1'b0, 1'b0, CC_NE, 9'h0, 16'h0, 3'b000);
        check("seq_addr2", bus.imem_addr, 16'h0004);
        check("seq_hlt", 16'(hlt), 16'h0);
        $display("seq: fetched 0x0000 0x0002 0x0004");

        // Three waiting cycles; a stray ack with a taken branch must be ignored
        lat = 3;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("wait_req",   16'(bus.imem_req), 16'h1);
            check("wait_addr",  bus.imem_addr, 16'h0004);
            check("wait_valid", 16'(bus.instr_valid), 16'h0);
            bus.br_en = 1'b1; bus.br_reg = 1'b1; bus.br_cond = CC_UNCOND; bus.br_target = 16'h4444;
            bus.instr_ack = 1'b1;
            @(negedge clk);
        end
        bus.instr_ack = 1'b0;
        bus.br_en     = 1'b0;
        wait_hold(cyc);
        check("wait_instr", bus.instr, 16'h1004);
        check("wait_pc",    pc, 16'h0004);
        lat = 0;
        $display("latency: 3-wait fetch at 0x0004 presented");

        // Branch vector table; each vector first jumps to its start PC
        for (int v = 0; v < 18; v++) begin
            ack(1'b1, 1'b1, CC_UNCOND, 9'h0, vecs[v].start_pc, 3'b000);
            check("jump_addr", bus.imem_addr, vecs[v].start_pc);
            wait_hold(cyc);
            e = vecs[v].start_pc;
            check("vec_pc",      pc, vecs[v].start_pc);
            check("vec_pc_plus", pc_plus, vecs[v].exp_plus);
            check("vec_instr",   bus.instr, {4'h1, e[11:0]});
            ack(vecs[v].br_en, vecs[v].br_reg, vecs[v].cond, vecs[v].off, vecs[v].tgt, vecs[v].flags);
            check("vec_next", bus.imem_addr, vecs[v].exp_next);
            $display("vec %0d: pc=0x%04h cond=%0d flags=%03b next=0x%04h", v, vecs[v].start_pc,
                     vecs[v].cond, vecs[v].flags, bus.imem_addr);
            wait_hold(cyc);
        end

        // HLT fetched at 0x0006: halts, ignores ack, leaves only on reset
        halt_addr = 16'h0006;
        ack(1'b1, 1'b1, CC_UNCOND, 9'h0, 16'h0006, 3'b000);
        check("halt_fetch_addr", bus.imem_addr, 16'h0006);
        @(negedge clk);
        check("halt_hlt",   16'(hlt), 16'h1);
        check("halt_pc",    pc, 16'h0006);
        check("halt_valid", 16'(bus.instr_valid), 16'h0);
        check("halt_req",   16'(bus.imem_req), 16'h0);
        bus.br_en = 1'b1; bus.br_reg = 1'b1; bus.br_cond = CC_UNCOND; bus.br_target = 16'h0100;
        bus.instr_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.instr_ack = 1'b0;
        bus.br_en     = 1'b0;
        check("halt_stay_hlt", 16'(hlt), 16'h1);
        check("halt_stay_pc",  pc, 16'h0006);
        rst = 1'b1;
        #1;
        check("halt_rst_req", 16'(bus.imem_req), 16'h0);
        @(negedge clk);
        rst = 1'b0;
        halt_addr = 16'hFFFF;
        #1;
        check("restart_hlt",  16'(hlt), 16'h0);
        check("restart_pc",   pc, 16'h0000);
        check("restart_addr", bus.imem_addr, 16'h0000);
        check("restart_req",  16'(bus.imem_req), 16'h1);
        $display("halt: stopped at 0x0006, restarted at 0x0000");

        // Reset in the middle of a slow fetch abandons it
        wait_hold(cyc);
        ack(1'b1, 1'b1, CC_UNCOND, 9'h0, 16'h0040, 3'b000);
        lat = 5;
        @(negedge clk);
        @(negedge clk);
        check("midwait_addr", bus.imem_addr, 16'h0040);
        rst = 1'b1;
        @(negedge clk);
        check("midwait_rst_instr", bus.instr, 16'h0000);
        check("midwait_rst_pc",    pc, 16'h0000);
        rst = 1'b0;
        lat = 0;
        #1;
        wait_hold(cyc);
        check("midwait_restart_instr", bus.instr, 16'h1000);
        $display("midwait: reset abandoned fetch at 0x0040");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
